// File: rtl/tick_debouncer_pkg.sv
// Shared types and default constants for the tick-paced debouncer.
package debounce_pkg;

    typedef enum logic [1:0] {S_LOW, S_WAIT_HI, S_HIGH, S_WAIT_LO} db_state_t;

    localparam int unsigned DB_N_STABLE = 4;
    localparam int unsigned DB_CNT_W    = 8;

endpackage

// File: rtl/tick_debouncer_if.sv
// Sample-enable, raw input and debounced outputs of the tick debouncer.
interface tick_debouncer_if #(
    parameter int unsigned CNT_W = debounce_pkg::DB_CNT_W
);
    logic             tick;
    logic             btn;
    logic             db_level;
    logic             db_rise;
    logic             db_fall;
    logic [CNT_W-1:0] press_cnt;

    modport master (
        output tick,
        output btn,
        input  db_level,
        input  db_rise,
        input  db_fall,
        input  press_cnt
    );

    modport slave (
        input  tick,
        input  btn,
        output db_level,
        output db_rise,
        output db_fall,
        output press_cnt
    );
endinterface

// File: rtl/tick_debouncer_sync_2ff.sv
// Two-flop synchronizer for an asynchronous single-bit input, resets to 0.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/tick_debouncer.sv
// Tick-paced debouncer: a new level is accepted after N_STABLE agreeing tick samples,
// with registered level, edge pulses and a wrapping press counter.
module tick_debouncer
    import debounce_pkg::*;
#(
    parameter int unsigned N_STABLE = DB_N_STABLE,
    parameter int unsigned CNT_W    = DB_CNT_W
) (
    input logic             clk,
    input logic             reset,
    tick_debouncer_if.slave bus
);
    localparam int unsigned CW = $clog2(N_STABLE + 1);
    // cnt + 1 == N_STABLE, expressed without the adder
    localparam logic [CW-1:0] LAST = CW'(N_STABLE - 1);

    if (N_STABLE < 2 || N_STABLE > 255) begin : g_bad_n_stable
        $error("tick_debouncer: N_STABLE must be in 2..255");
    end

    logic btn_s;

    sync_2ff u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (bus.btn),
        .q     (btn_s)
    );

    db_state_t        state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             rise_d, fall_d;
    logic             rise_q, fall_q, level_q;
    logic [CNT_W-1:0] press_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_LOW;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            level_q <= 1'b0;
            press_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            level_q <= (state_d == S_HIGH) || (state_d == S_WAIT_LO);
            if (rise_d) begin
                press_q <= press_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (bus.tick) begin
            unique case (state_q)
                S_LOW: begin
                    if (btn_s) begin
                        state_d = S_WAIT_HI;
                        cnt_d   = CW'(1);
                    end else begin
                        cnt_d = '0;
                    end
                end
                S_WAIT_HI: begin
                    if (!btn_s) begin
                        state_d = S_LOW;
                        cnt_d   = '0;
                    end else if (cnt_q == LAST) begin
                        state_d = S_HIGH;
                        cnt_d   = '0;
                        rise_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_HIGH: begin
                    if (!btn_s) begin
                        state_d = S_WAIT_LO;
                        cnt_d   = CW'(1);
                    end else begin
                        cnt_d = '0;
                    end
                end
                S_WAIT_LO: begin
                    if (btn_s) begin
                        state_d = S_HIGH;
                        cnt_d   = '0;
                    end else if (cnt_q == LAST) begin
                        state_d = S_LOW;
                        cnt_d   = '0;
                        fall_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        bus.db_level  = level_q;
        bus.db_rise   = rise_q;
        bus.db_fall   = fall_q;
        bus.press_cnt = press_q;
    end
endmodule

// File: tb/tb_tick_debouncer.sv
// Randomized and directed bench for tick_debouncer against a run-length reference model.
module tb_tick_debouncer;
    localparam int unsigned N = 4;
    localparam int unsigned W = 2;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    tick_debouncer_if #(.CNT_W(W)) bus ();

    tick_debouncer #(.N_STABLE(N), .CNT_W(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference: btn delayed two clocks; on each tick, count consecutive samples
    // disagreeing with the current level and flip the level when the run reaches N.
    logic         m_s1, m_s2, m_level, m_rise, m_fall;
    int           m_run;
    logic [W-1:0] m_cnt;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_s1 <= 1'b0; m_s2 <= 1'b0; m_level <= 1'b0;
            m_rise <= 1'b0; m_fall <= 1'b0; m_run <= 0; m_cnt <= '0;
        end else begin
            m_s1   <= bus.btn;
            m_s2   <= m_s1;
            m_rise <= 1'b0;
            m_fall <= 1'b0;
            if (bus.tick) begin
                if (m_s2 == m_level) begin
                    m_run <= 0;
                end else if (m_run + 1 == N) begin
                    m_run   <= 0;
                    m_level <= m_s2;
                    m_rise  <= m_s2;
                    m_fall  <= !m_s2;
                    if (m_s2) m_cnt <= m_cnt + 1'b1;
                end else begin
                    m_run <= m_run + 1;
                end
            end
        end
    end

    task automatic test_reset();
        bus.tick = 1'b1;
        bus.btn  = 1'b0;
        reset    = 1'b1;
        repeat (10) begin
            #2 bus.btn = ~bus.btn;
        end
        checks++;
        if ({bus.db_level, bus.db_rise, bus.db_fall, bus.press_cnt} !== 5'b0) begin
            errors++;
            $display("FAIL reset_hold: got lvl/rise/fall/cnt=%b/%b/%b/%0d want 0/0/0/0",
                     bus.db_level, bus.db_rise, bus.db_fall, bus.press_cnt);
        end
        @(negedge clk);
        bus.btn = 1'b0;
        reset   = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.db_level, bus.db_rise, bus.db_fall, bus.press_cnt} !==
                {m_level, m_rise, m_fall, m_cnt}) begin
                errors++;
                $display("FAIL reset_settle @%0t: got %b/%b/%b/%0d want %b/%b/%b/%0d", $time,
                         bus.db_level, bus.db_rise, bus.db_fall, bus.press_cnt,
                         m_level, m_rise, m_fall, m_cnt);
            end
        end
    endtask

    task automatic test_mid_reset();
        bit found = 1'b0;
        int rises = 0;
        int rise_iter = -1;
        for (int i = 0; i < 20 && !found; i++) begin
            bus.btn  = 1'b1;
            bus.tick = 1'b1;
            @(negedge clk);
            checks++;
            if ({bus.db_level, bus.db_rise, bus.db_fall, bus.press_cnt} !==
                {m_level, m_rise, m_fall, m_cnt}) begin
                errors++;
                $display("FAIL mid_reset_arm @%0t: got %b/%b/%b/%0d want %b/%b/%b/%0d", $time,
                         bus.db_level, bus.db_rise, bus.db_fall, bus.press_cnt,
                         m_level, m_rise, m_fall, m_cnt);
            end
            if (m_run == 3 && !m_level) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL mid_reset_arm: got no run of 3 want run of 3 within 20 clk");
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({bus.db_level, bus.db_rise, bus.db_fall, bus.press_cnt} !== 5'b0) begin
            errors++;
            $display("FAIL mid_reset_abort: got lvl/rise/fall/cnt=%b/%b/%b/%0d want 0/0/0/0",
                     bus.db_level, bus.db_rise, bus.db_fall, bus.press_cnt);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        // btn is still high: a fresh N-tick debounce must follow the reset
        for (int i = 0; i < 15; i++) begin
            bus.btn  = 1'b1;
            bus.tick = 1'b1;
            @(negedge clk);
            checks++;
            if ({bus.db_level, bus.db_rise, bus.db_fall, bus.press_cnt} !==
                {m_level, m_rise, m_fall, m_cnt}) begin
                errors++;
                $display("FAIL mid_reset_redo @%0t: got %b/%b/%b/%0d want %b/%b/%b/%0d", $time,
                         bus.db_level, bus.db_rise, bus.db_fall, bus.press_cnt,
                         m_level, m_rise, m_fall, m_cnt);
            end
            if (bus.db_rise) begin
                rises++;
                if (rise_iter < 0) rise_iter = i;
            end
        end
        checks++;
        if (rises != 1 || rise_iter != 5) begin
            errors++;
            $display("FAIL mid_reset_redo_rise: got %0d rises at iter %0d want 1 at iter 5",
                     rises, rise_iter);
        end
        for (int i = 0; i < 15; i++) begin
            bus.btn  = 1'b0;
            bus.tick = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic test_clean_press();
        int rises = 0;
        int falls = 0;
        int rise_iter = -1;
        for (int i = 0; i < 70; i++) begin
            bus.btn  = 1'b1;
            bus.tick = (i % 10 == 0);
            @(negedge clk);
            checks++;
            if ({bus.db_level, bus.db_rise, bus.db_fall, bus.press_cnt} !==
                {m_level, m_rise, m_fall, m_cnt}) begin
                errors++;
                $display("FAIL clean_press @%0t: got %b/%b/%b/%0d want %b/%b/%b/%0d", $time,
                         bus.db_level, bus.db_rise, bus.db_fall, bus.press_cnt,
                         m_level, m_rise, m_fall, m_cnt);
            end
            if (bus.db_rise) begin
                rises++;
                if (rise_iter < 0) rise_iter = i;
            end
        end
        checks++;
        if (rises != 1 || rise_iter != 40 || bus.press_cnt !== 2'd2 || bus.db_level !== 1'b1) begin
            errors++;
            $display("FAIL clean_press_result: got rises=%0d at %0d cnt=%0d lvl=%b want 1 at 40 2 1",
                     rises, rise_iter, bus.press_cnt, bus.db_level);
        end
        for (int i = 0; i < 15; i++) begin
            bus.btn  = 1'b0;
            bus.tick = 1'b1;
            @(negedge clk);
            checks++;
            if ({bus.db_level, bus.db_rise, bus.db_fall, bus.press_cnt} !==
                {m_level, m_rise, m_fall, m_cnt}) begin
                errors++;
                $display("FAIL clean_release @%0t: got %b/%b/%b/%0d want %b/%b/%b/%0d", $time,
                         bus.db_level, bus.db_rise, bus.db_fall, bus.press_cnt,
                         m_level, m_rise, m_fall, m_cnt);
            end
            if (bus.db_fall) falls++;
        end
        checks++;
        if (falls != 1) begin
            errors++;
            $display("FAIL clean_release_fall: got %0d falls want 1", falls);
        end
    endtask

    task automatic test_bounce();
        logic pat [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        int rises = 0;
        int rise_iter = -1;
        for (int i = 0; i < 40; i++) begin
            bus.btn  = (i / 4 < 7) ? pat[i / 4] : 1'b1;
            bus.tick = (i % 4 == 0);
            @(negedge clk);
            checks++;
            if ({bus.db_level, bus.db_rise, bus.db_fall, bus.press_cnt} !==
                {m_level, m_rise, m_fall, m_cnt}) begin
                errors++;
                $display("FAIL bounce @%0t: got %b/%b/%b/%0d want %b/%b/%b/%0d", $time,
                         bus.db_level, bus.db_rise, bus.db_fall, bus.press_cnt,
                         m_level, m_rise, m_fall, m_cnt);
            end
            if (bus.db_rise) begin
                rises++;
                if (rise_iter < 0) rise_iter = i;
            end
        end
        checks++;
        if (rises != 1 || rise_iter != 28 || bus.press_cnt !== 2'd3) begin
            errors++;
            $display("FAIL bounce_result: got rises=%0d at %0d cnt=%0d want 1 at 28 cnt 3",
                     rises, rise_iter, bus.press_cnt);
        end
        for (int i = 0; i < 15; i++) begin
            bus.btn  = 1'b0;
            bus.tick = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic test_tick_gating();
        int rises = 0;
        int rise_iter = -1;
        for (int i = 0; i < 100; i++) begin
            bus.btn  = 1'b1;
            bus.tick = 1'b0;
            @(negedge clk);
            checks++;
            if ({bus.db_level, bus.db_rise, bus.db_fall, bus.press_cnt} !==
                {m_level, m_rise, m_fall, m_cnt}) begin
                errors++;
                $display("FAIL tick_gated @%0t: got %b/%b/%b/%0d want %b/%b/%b/%0d", $time,
                         bus.db_level, bus.db_rise, bus.db_fall, bus.press_cnt,
                         m_level, m_rise, m_fall, m_cnt);
            end
        end
        checks++;
        if (bus.db_level !== 1'b0 || bus.press_cnt !== 2'd3) begin
            errors++;
            $display("FAIL tick_gated_hold: got lvl=%b cnt=%0d want lvl=0 cnt=3",
                     bus.db_level, bus.press_cnt);
        end
        for (int i = 0; i < 10; i++) begin
            bus.btn  = 1'b1;
            bus.tick = 1'b1;
            @(negedge clk);
            checks++;
            if ({bus.db_level, bus.db_rise, bus.db_fall, bus.press_cnt} !==
                {m_level, m_rise, m_fall, m_cnt}) begin
                errors++;
                $display("FAIL tick_resume @%0t: got %b/%b/%b/%0d want %b/%b/%b/%0d", $time,
                         bus.db_level, bus.db_rise, bus.db_fall, bus.press_cnt,
                         m_level, m_rise, m_fall, m_cnt);
            end
            if (bus.db_rise) begin
                rises++;
                if (rise_iter < 0) rise_iter = i;
            end
        end
        checks++;
        if (rises != 1 || rise_iter != 3 || bus.press_cnt !== 2'd0) begin
            errors++;
            $display("FAIL tick_resume_result: got rises=%0d at %0d cnt=%0d want 1 at 3 cnt 0",
                     rises, rise_iter, bus.press_cnt);
        end
        for (int i = 0; i < 15; i++) begin
            bus.btn  = 1'b0;
            bus.tick = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic test_wrap();
        logic [W-1:0] exp_seq [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        bus.btn = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int p = 0; p < 5; p++) begin
            int rises = 0;
            int falls = 0;
            for (int i = 0; i < 40; i++) begin
                bus.btn  = (i < 20);
                bus.tick = (i % 2 == 0);
                @(negedge clk);
                checks++;
                if ({bus.db_level, bus.db_rise, bus.db_fall, bus.press_cnt} !==
                    {m_level, m_rise, m_fall, m_cnt}) begin
                    errors++;
                    $display("FAIL wrap @%0t: got %b/%b/%b/%0d want %b/%b/%b/%0d", $time,
                             bus.db_level, bus.db_rise, bus.db_fall, bus.press_cnt,
                             m_level, m_rise, m_fall, m_cnt);
                end
                if (bus.db_rise) rises++;
                if (bus.db_fall) falls++;
                if (i == 19) begin
                    checks++;
                    if (rises != 1 || bus.press_cnt !== exp_seq[p]) begin
                        errors++;
                        $display("FAIL wrap_press%0d: got rises=%0d cnt=%0d want 1 cnt=%0d",
                                 p, rises, bus.press_cnt, exp_seq[p]);
                    end
                end
            end
            checks++;
            if (falls != 1) begin
                errors++;
                $display("FAIL wrap_release%0d: got %0d falls want 1", p, falls);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            // alternate noisy and quiet stretches so both rejection and acceptance occur
            int unsigned flip_max = ((i / 200) % 2 == 0) ? 3 : 31;
            if ($urandom_range(0, flip_max) == 0) bus.btn = ~bus.btn;
            bus.tick = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            checks++;
            if ({bus.db_level, bus.db_rise, bus.db_fall, bus.press_cnt} !==
                {m_level, m_rise, m_fall, m_cnt} || (bus.db_rise && bus.db_fall)) begin
                errors++;
                $display("FAIL random @%0t: got %b/%b/%b/%0d want %b/%b/%b/%0d", $time,
                         bus.db_level, bus.db_rise, bus.db_fall, bus.press_cnt,
                         m_level, m_rise, m_fall, m_cnt);
            end
        end
    endtask

    initial begin
        bus.tick = 1'b0;
        bus.btn  = 1'b0;
        test_reset();
        test_mid_reset();
        test_clean_press();
        test_bounce();
        test_tick_gating();
        test_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/tick_debouncer.md
# tick_debouncer

Tick-paced input debouncer sitting directly downstream of the `fsm_tick` / `fsm_tick_en` tick generators. It samples a raw, asynchronous push-button or switch input only on cycles where the tick enable is high. It declares a new stable level after `N_STABLE` consecutive agreeing samples, then emits the debounced level, one-cycle edge pulses and a wrapping press count for downstream control logic.

## Interface
- `N_STABLE`, default 4: consecutive agreeing tick samples required to change level; legal range 2..255.
- `CNT_W`, default 8: width of the press counter.

- `clk`  in  1: system clock; all flops on rising edge.
- `reset`  in  1: asynchronous, active-high reset. One clock; reset is asynchronous and active-high.
- `tick`  in  1: one-clk-wide sample enable from the tick generator; may also be tied high.
- `btn`  in  1: raw asynchronous input, may bounce.
- `db_level`  out  1: debounced level, registered.
- `db_rise`  out  1: one-clk pulse on debounced 0->1.
- `db_fall`  out  1: one-clk pulse on debounced 1->0.
- `press_cnt`  out  CNT_W: count of `db_rise` events, wraps.

## Operation
- Synchronizer:
  - `btn` passes through a 2-flop synchronizer to produce `btn_s`.
  - Only `btn_s` is used downstream.
- FSM states: `S_LOW`, `S_WAIT_HI`, `S_HIGH`, `S_WAIT_LO`. A sample counter `cnt` of width `$clog2(N_STABLE+1)` accompanies the FSM.
- State and `cnt` change only on cycles where `tick`=1. With `tick`=0 everything holds, and the pulse outputs are 0.
- `S_LOW`:
  - `btn_s`=1 -> `S_WAIT_HI`, `cnt`=1.
  - Otherwise stay in `S_LOW`, `cnt`=0.
- `S_WAIT_HI`:
  - `btn_s`=0 -> `S_LOW`, `cnt`=0. This is a glitch rejection; no pulse.
  - `btn_s`=1 and `cnt`+1==`N_STABLE` -> `S_HIGH`, `cnt`=0, assert `db_rise`.
  - Otherwise `cnt`+=1.
- `S_HIGH` and `S_WAIT_LO` are the mirror image with `btn_s` inverted; the transition out of `S_WAIT_LO` asserts `db_fall`.
- `db_level`=1 in `S_HIGH` and `S_WAIT_LO`, 0 in `S_LOW` and `S_WAIT_HI`. The level does not change while waiting.
- `press_cnt`:
  - Increments by 1 in the same cycle `db_rise` is registered.
  - Wraps (2^CNT_W - 1) -> 0 with no saturation or flag.
- `db_rise` and `db_fall` are never high simultaneously.

## Timing
- Reset (async assert, sync-safe deassert by the driving logic): state `S_LOW`, `cnt`=0, sync flops 0, `db_level`=0, `db_rise`=0, `db_fall`=0, `press_cnt`=0.
- Reset mid-debounce aborts immediately: no pulse and no count increment.
- Synchronizer latency is 2 clk from a `btn` edge to `btn_s`.
- Debounce latency is `N_STABLE` ticks from the first tick that sees a changed `btn_s`.
- Output timing:
  - `db_level`, `db_rise`, `db_fall` and `press_cnt` are all registered.
  - They update on the clock edge that consumes the final qualifying tick, so outputs change 1 clk after that tick cycle.
  - The pulse lasts exactly 1 clk.
- With `tick` tied 1, the block debounces per clock: the level changes `N_STABLE` clk after `btn_s` changes.
- A `tick` arriving in the same cycle as a `btn_s` change uses the new `btn_s` value.

## Structure
- Package `debounce_pkg`:
  - `typedef enum logic [1:0] {S_LOW, S_WAIT_HI, S_HIGH, S_WAIT_LO} db_state_t`.
  - Default constants `DB_N_STABLE=4` and `DB_CNT_W=8`.
- Sub-module `sync_2ff`: 2-flop synchronizer with async active-high reset to 0.
- Top `tick_debouncer` contains:
  - An `always_ff` block for state, `cnt`, outputs and `press_cnt`.
  - An `always_comb` block for next state.
  - An elaboration-time assertion that `N_STABLE` >= 2.

## Test plan
- Reset hold: `reset`=1 for 20 ns while `btn` toggles -> all outputs 0, `press_cnt`=0.
- Clean press:
  - Stimulus: `N_STABLE`=4, tick every 10 clk, `btn` 0->1 held.
  - Response: `db_level` rises after 4 ticks plus sync latency; exactly one `db_rise` 1 clk wide; `press_cnt`=1.
- Bounce rejection: `btn`=1 for 2 ticks, 0 for 1 tick, then 1 for 4 ticks -> a single `db_rise` only after the final 4 ticks; `press_cnt`=1.
- Tick gating: `tick` held 0 for 100 clk with `btn`=1 -> no state change; resuming ticks completes the debounce.
- Release and wrap:
  - Stimulus: `CNT_W`=2, 5 clean presses and releases.
  - Response: `db_fall` pulse after each release; `press_cnt` sequence 1,2,3,0,1.
- Async reset mid-operation: assert `reset` during `S_WAIT_HI` with `cnt`=3 -> immediate `S_LOW`, no `db_rise`, `press_cnt` unchanged at 0.
